// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
// The MUL_SIGNED_EN option is handled in seq_multiplier; nothing here depends on it.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int unsigned BPC_1 = 1;
  localparam int unsigned BPC_2 = 2;
  localparam int unsigned BPC_4 = 4;

  // The counter must hold WIDTH/BITS_PER_CYCLE itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic bit bpc_legal(input int unsigned bpc);
    return (bpc == BPC_1) || (bpc == BPC_2) || (bpc == BPC_4);
  endfunction

endpackage

// File: rtl/mul_partial.sv
// Combinational partial-product generator: sum of the multiplicand shifted
// by each set bit of the current multiplier slice.
module mul_partial #(
  parameter int unsigned PW  = 64,
  parameter int unsigned BPC = 1
) (
  input  logic [PW-1:0]  mcand_i,
  input  logic [BPC-1:0] bits_i,
  output logic [PW-1:0]  pp_o
);

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < BPC; i++) begin
      if (bits_i[i]) pp_o = pp_o + (mcand_i << i);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Define MUL_SIGNED_EN to add the signed_op port and two's-complement operation.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  if ((WIDTH % BITS_PER_CYCLE) != 0 || !bpc_legal(BITS_PER_CYCLE) || WIDTH < 4) begin : g_cfg_err
    $fatal(1, "seq_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  mul_state_e        state_q, state_d;
  logic              load, finish;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     mcand_q, acc_q, product_q, pp, acc_sum;
  logic [WIDTH-1:0]  mplier_q;
  logic              neg_q;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;

`ifdef MUL_SIGNED_EN
  assign a_neg = signed_op & op_a[WIDTH-1];
  assign b_neg = signed_op & op_b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == ONE_CNT) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  mul_partial #(
    .PW  (PW),
    .BPC (BITS_PER_CYCLE)
  ) u_partial (
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
    .pp_o    (pp)
  );

  assign acc_sum = acc_q + pp;

  // Datapath registers carry no reset; load always precedes their use.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      neg_q    <= a_neg ^ b_neg;
    end else if (state_q == RUN) begin
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      acc_q    <= acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      if (load)                 cnt_q <= N_CNT;
      else if (state_q == RUN)  cnt_q <= cnt_q - ONE_CNT;
      if (finish) product_q <= apply_sign(acc_sum, neg_q);
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level reference model plus directed cases.
module tb_seq_multiplier;

  localparam int N1 = 32;
  localparam int N4 = 8;

  logic        clk = 1'b0;
  logic        reset, start, signed_op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] product;

  logic        start4, signed4;
  logic [31:0] a4, b4;
  logic        busy4, done4;
  logic [63:0] product4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
`ifdef MUL_SIGNED_EN
    .signed_op (signed4),
`endif
    .op_a      (a4),
    .op_b      (b4),
    .busy      (busy4),
    .done      (done4),
    .product   (product4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Reference model: an accepted start yields a*b exactly N1 edges later.
  int          rem = 0;
  logic [63:0] pend = '0, m_prod = '0;
  logic        m_done = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic s;
`ifdef MUL_SIGNED_EN
    s = signed_op;
`else
    s = 1'b0;
`endif
    if (reset === 1'b1) begin
      rem = 0; m_done = 1'b0; m_prod = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (rem > 0) begin
        rem--;
        m_done = (rem == 0);
        if (m_done) m_prod = pend;
      end else begin
        m_done = 1'b0;
        if (start === 1'b1) begin
          rem  = N1;
          pend = ref_prod(op_a, op_b, s);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", 64'(busy), 64'(rem > 0));
      check("model_done", 64'(done), 64'(m_done));
      check("model_product", product, m_prod);
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    op_a = a; op_b = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(input int limit, output int lat, output int bcyc);
    lat = -1; bcyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    @(posedge clk); #1;
    a4 = a; b4 = b; signed4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = $urandom; b4 = $urandom;
    lat = -1;
    for (int i = 1; i <= N4 + 10; i++) begin
      @(negedge clk);
      if (done4) begin
        lat = i - 1;
        break;
      end
    end
    check("bpc4_latency", 64'(lat), 64'(N4));
    check("bpc4_product", product4, exp);
  endtask

  initial begin
    int lat, bcyc, ndone;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    start4 = 1'b0; signed4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);

    start_op(32'd3, 32'd5, 1'b0);
    wait_done(N1 + 10, lat, bcyc);
    check("small_latency", 64'(lat), 64'd32);
    check("small_busy_cycles", 64'(bcyc), 64'd32);
    check("small_product", product, 64'h000000000000000F);

    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(N1 + 10, lat, bcyc);
    check("max_unsigned", product, 64'hFFFFFFFE00000001);

`ifdef MUL_SIGNED_EN
    start_op(32'hFFFFFFF9, 32'd6, 1'b1);
    wait_done(N1 + 10, lat, bcyc);
    check("signed_neg7x6", product, 64'hFFFFFFFFFFFFFFD6);
    start_op(32'h80000000, 32'h80000000, 1'b1);
    wait_done(N1 + 10, lat, bcyc);
    check("signed_minxmin", product, 64'h4000000000000000);
`endif

    // A second start 10 cycles into RUN must be dropped.
    start_op(32'd100, 32'd200, 1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(N1 + 10, lat, bcyc);
    check("ignore_latency", 64'(lat), 64'd22);
    check("ignore_product", product, 64'd20000);

    // Back-to-back: start raised during the done cycle.
    op_a = 32'd11; op_b = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(N1 + 10, lat, bcyc);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_product", product, 64'd143);

    start_op(32'h1234, 32'h5678, 1'b0);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'h1 : $urandom;
      op_a = ra; op_b = rb;
`ifdef MUL_SIGNED_EN
      signed_op = $urandom_range(0, 1);
`endif
    end
    #1 start = 1'b0;
    repeat (40) @(posedge clk);

    run4(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);
    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom;
      run4(ra, rb, ref_prod(ra, rb, 1'b0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised multi-cycle shift-add integer multiplier for the execute stage, feeding the HI/LO register pair. It accepts one operand pair per start request, retires BITS_PER_CYCLE multiplier bits per clock, and reports completion with a single-cycle done pulse. The product register is written only at completion, so HI/LO can capture it on done without extra gating.

## Interface
- WIDTH, 32: operand width in bits; must be ≥4 and a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1: multiplier bits consumed per RUN cycle; legal values 1, 2, 4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- signed_op  in  1  1 = two's-complement operands; present only with MUL_SIGNED_EN.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result; holds until the next completion.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE; product=0, busy=0, done=0, counter=0.
- IDLE/DONE with start=1: latch op_a (zero-extended to 2*WIDTH) and op_b, clear the accumulator, load counter = WIDTH/BITS_PER_CYCLE, go to RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN: accumulator += multiplicand × multiplier[BITS_PER_CYCLE-1:0]. Then shift the multiplicand left and the multiplier right by BITS_PER_CYCLE, and decrement the counter. When the counter reaches 1, that edge writes the final sum to product and enters DONE.
- start while busy=1 is ignored; no queuing. op_a/op_b are don't-care after the start edge.
- All arithmetic is modulo 2^(2*WIDTH). Unsigned results never overflow.
- reset during RUN aborts the operation: IDLE, product=0, no done pulse.

## Timing
- Start sampled at edge E0. RUN occupies the cycles after E0 through edge EN, where N = WIDTH/BITS_PER_CYCLE. done=1 and the new product are visible in the cycle after EN.
- Start to done latency: N cycles (32 for the defaults).
- busy=1 in exactly N cycles. busy=0 in the done cycle.
- Back-to-back: start asserted in the done cycle is accepted. Throughput is one result per N+1 cycles.
- product changes only at the edge entering DONE, or at reset.

## Configuration
- MUL_SIGNED_EN defined:
  - The signed_op port exists.
  - When signed_op=1 at start, the operand magnitudes are latched (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned) and the sign XOR is stored.
  - The unsigned product is two's-complement negated as it is written at completion. Latency is unchanged.
- MUL_SIGNED_EN undefined: no signed_op port; unsigned only. Logic is identical to the signed_op=0 path.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the legal BITS_PER_CYCLE constants;
  - the localparam for counter width, $clog2(WIDTH/BITS_PER_CYCLE + 1).
- Elaboration-time check: WIDTH % BITS_PER_CYCLE == 0, otherwise $fatal.
- Sub-module mul_partial: combinational 2*WIDTH × BITS_PER_CYCLE partial product generator (shifted-add tree). Instantiated once.

## Test plan
- WIDTH=32, BPC=1: op_a=3, op_b=5, start → done exactly 32 cycles later, product=0x000000000000000F. busy high for 32 cycles.
- op_a=op_b=0xFFFFFFFF unsigned → product=0xFFFFFFFE00000001.
- MUL_SIGNED_EN, signed_op=1:
  - op_a=−7 (0xFFFFFFF9), op_b=6 → 0xFFFFFFFFFFFFFFD6.
  - op_a=op_b=0x80000000 → 0x4000000000000000.
- start pulsed again 10 cycles into RUN with different operands → ignored; the original product is returned at cycle 32. A start in the done cycle launches the next operation.
- reset asserted at cycle 15 of RUN → next cycle IDLE, busy=0, product=0, and no done pulse ever appears.
- BITS_PER_CYCLE=4: op_a=0x12345678, op_b=0x9ABCDEF0 → done 8 cycles after start, product=0x0B00EA4E242D2080.
